// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports with write-through
// bypass, two write ports, post-reset init sweep and a pending scoreboard.
module reg_file_mp #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 4,
  parameter bit                 ZERO_R0 = 1'b0,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rpend1,
  output logic              rpend2,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              ready
);

  localparam int              NREGS    = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS-1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W:0]   cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  pend_r, pend_nxt_s;
  logic [NREGS-1:0]  clr_mask_s, set_mask_s;

  logic              run_s;
  logic              wr0_s, wr1_s;
  logic              sb_ok_s;

  logic [ADDR_W-1:0] raddr_s [2];
  logic [DATA_W-1:0] rdata_s [2];
  logic              rpend_s [2];

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    return {{(NREGS-1){1'b0}}, 1'b1} << a;
  endfunction

  assign run_s = (state_r == RUN);

  // R0 writes vanish when hardwired; port 0 yields to port 1 on an address clash.
  assign wr1_s   = run_s && wen1 && !(ZERO_R0 && (waddr1 == ADDR_ZERO));
  assign wr0_s   = run_s && wen0 && !(ZERO_R0 && (waddr0 == ADDR_ZERO))
                   && !(wen1 && (waddr1 == waddr0));
  assign sb_ok_s = run_s && sb_set && !(ZERO_R0 && (sb_addr == ADDR_ZERO));

  // FSM state and init counter register.
  always_ff @(posedge clk) begin
    state_r <= state_nxt_s;
    cnt_r   <= cnt_nxt_s;
  end

  // Next-state logic: reset restarts the sweep from any state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (rst) begin
      state_nxt_s = INIT;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        INIT: begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = INIT;
          end
        end
        RUN: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = cnt_r;
        end
        default: begin
          state_nxt_s = INIT;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Array update: init sweep, otherwise the two writeback ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == INIT) begin
        regs_r[cnt_r[ADDR_W-1:0]] <= RST_VAL;
      end else begin
        if (wr0_s) regs_r[waddr0] <= wdata0;
        if (wr1_s) regs_r[waddr1] <= wdata1;
      end
    end
  end

  // Scoreboard masks: set is applied after clear so a new producer wins.
  always_comb begin
    clr_mask_s = {NREGS{1'b0}};
    set_mask_s = {NREGS{1'b0}};
    pend_nxt_s = pend_r;
    if (rst) begin
      pend_nxt_s = {NREGS{1'b0}};
    end else if (run_s) begin
      clr_mask_s = (wen0 ? onehot(waddr0) : {NREGS{1'b0}})
                 | (wen1 ? onehot(waddr1) : {NREGS{1'b0}});
      set_mask_s = sb_ok_s ? onehot(sb_addr) : {NREGS{1'b0}};
      pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
    end else begin
      pend_nxt_s = {NREGS{1'b0}};
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    pend_r <= pend_nxt_s;
  end

  assign raddr_s[0] = raddr1;
  assign raddr_s[1] = raddr2;

  // Read ports: R0 override, then port-1 bypass, port-0 bypass, array.
  always_comb begin
    rdata_s[0] = RST_VAL;
    rdata_s[1] = RST_VAL;
    rpend_s[0] = 1'b0;
    rpend_s[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (!run_s) begin
        rdata_s[p] = RST_VAL;
        rpend_s[p] = 1'b0;
      end else if (ZERO_R0 && (raddr_s[p] == ADDR_ZERO)) begin
        rdata_s[p] = {DATA_W{1'b0}};
        rpend_s[p] = 1'b0;
      end else if (wen1 && (waddr1 == raddr_s[p])) begin
        rdata_s[p] = wdata1;
        rpend_s[p] = 1'b0;
      end else if (wen0 && (waddr0 == raddr_s[p])) begin
        rdata_s[p] = wdata0;
        rpend_s[p] = 1'b0;
      end else begin
        rdata_s[p] = regs_r[raddr_s[p]];
        rpend_s[p] = pend_r[raddr_s[p]];
      end
    end
  end

  assign rdata1 = rdata_s[0];
  assign rdata2 = rdata_s[1];
  assign rpend1 = rpend_s[0];
  assign rpend2 = rpend_s[1];
  assign ready  = run_s;

  reg_file_mp_chk #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ZERO_R0(ZERO_R0),
    .RST_VAL(RST_VAL)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .rpend1(rpend1),
    .rpend2(rpend2),
    .pend  (pend_r)
  );

endmodule

// Invariant checks for reg_file_mp; carries no functional logic.
module reg_file_mp_chk #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 4,
  parameter bit                 ZERO_R0 = 1'b0,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  ready,
  input logic [ADDR_W-1:0]     raddr1,
  input logic [DATA_W-1:0]     rdata1,
  input logic [DATA_W-1:0]     rdata2,
  input logic                  rpend1,
  input logic                  rpend2,
  input logic [2**ADDR_W-1:0]  pend
);

  logic seen_rst_r;

  // Arm the checks once the first reset has been applied.
  always_ff @(posedge clk) begin
    if (rst) seen_rst_r <= 1'b1;
  end

  a_init_outputs: assert property (@(posedge clk) disable iff (rst || !seen_rst_r)
    !ready |-> (rdata1 == RST_VAL) && (rdata2 == RST_VAL) && !rpend1 && !rpend2);

  a_r0_never_pending: assert property (@(posedge clk) disable iff (rst || !seen_rst_r)
    !(ZERO_R0 && pend[0]));

  a_r0_reads_zero: assert property (@(posedge clk) disable iff (rst || !seen_rst_r)
    (ZERO_R0 && ready && (raddr1 == {ADDR_W{1'b0}})) |-> (rdata1 == {DATA_W{1'b0}}) && !rpend1);

endmodule
